waveform_playback_sequencer: RTL and testbench
==============================================

# waveform_playback_sequencer

- Parametrised multi-channel address sequencer for the SPI-loaded waveform memories feeding the OSERDES outputs.
- Each channel sweeps its own start/end region and asserts a data-valid aligned to the memory read latency.
- Adds triggered single-pass and N-pass modes to the existing free-running loop.
- Emits a scope-trigger sync pulse aligned with channel 0's first word of each pass.

## Interface
Parameters:
- CHANNELS, 6: number of independent playback channels
- ADDR_WIDTH, 14: word address width per channel
- READ_LATENCY, 2: memory read latency in clocks; sets the valid/sync delay
- PASS_WIDTH, 16: width of the pass counter and loop_count

Ports:
- clock  in  1  word clock; the only clock
- reset  in  1  synchronous, active-high
- enable  in  1  low forces IDLE
- mode  in  2  0 = continuous, 1 = triggered single pass, 2 = triggered N passes, 3 = treated as 1
- loop_count  in  PASS_WIDTH  passes for mode 2; 0 is treated as 1
- trigger  in  1  single-cycle start request
- resync  in  1  single-cycle restart of all channels
- start_address  in  CHANNELS*ADDR_WIDTH  channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
- end_address  in  CHANNELS*ADDR_WIDTH  exclusive end, same packing
- read_address  out  CHANNELS*ADDR_WIDTH  memory read addresses
- read_enable  out  CHANNELS  channel address is live
- word_valid  out  CHANNELS  read_enable delayed READ_LATENCY; marks valid memory data
- sync_out  out  1  pass-start pulse, delayed READ_LATENCY
- busy  out  1  state is PLAY
- done  out  1  one-cycle pulse on sequence completion
- passes_done  out  PASS_WIDTH  completed channel-0 passes since the last start; saturates

## Operation
- States: IDLE, PLAY, DONE.
  - IDLE→PLAY: enable and mode 0 (no trigger needed), or enable and trigger in modes 1/2.
  - PLAY→DONE: modes 1/2, once every channel is finished.
  - DONE→IDLE: unconditional, after 1 cycle.
  - any state → IDLE: enable low (checked after reset).
- Entering PLAY:
  - every channel latches its start/end; read_address = start.
  - passes_done clears; per-channel pass counters clear.
- Each PLAY cycle, per channel:
  - if address == end-1 (last word): pass complete; increment the channel pass counter.
    - channel passes < target: relatch start/end and reload start.
    - otherwise: finished; read_enable low, address held.
  - else: address + 1.
- Target passes: mode 0 = infinite; mode 1 = 1; mode 2 = max(loop_count, 1). loop_count is sampled on PLAY entry.
- Empty region (end <= start, unsigned): the channel is finished immediately on entry and never asserts read_enable. An empty channel 0 never pulses sync.
- New start/end values take effect only at that channel's next pass boundary or on resync; there are no mid-pass changes.
- resync in PLAY: all channels relatch and restart at start; pass counters and passes_done clear; sync fires. resync in IDLE/DONE is ignored.
- trigger in PLAY or DONE is ignored; there is no retrigger.
- trigger and resync together in PLAY: resync wins.
- passes_done increments at each channel-0 pass completion, saturating at all-ones.
- Arithmetic is unsigned ADDR_WIDTH; no wrap past 2^ADDR_WIDTH-1 because end is exclusive.

## Timing
- Reset values: state IDLE; read_address 0; read_enable, word_valid, sync_out, busy, done = 0; passes_done = 0; delay lines cleared.
- Start latency:
  - trigger sampled at edge t → PLAY, read_address = start, read_enable = 1 in cycle t+1.
  - mode 0: PLAY one cycle after enable is sampled high.
- word_valid[c] = read_enable[c] delayed exactly READ_LATENCY clocks.
- sync_out:
  - internal pulse in the cycle channel 0 presents start (PLAY entry, wrap or resync), delayed READ_LATENCY.
  - therefore coincides with the first word_valid of channel 0's pass.
- Wrap costs zero cycles: end-1 is followed directly by start; word_valid stays continuous across passes.
- done: asserted in the DONE cycle, i.e. the cycle after the last channel finishes.
  - word_valid of the final words may still be high through READ_LATENCY further cycles.
- Reset mid-PLAY: all outputs reach reset values at the next edge; the delay lines are flushed, so no stale word_valid or sync_out.

## Structure
- Package waveform_playback_pkg:
  - mode constants MODE_CONTINUOUS, MODE_SINGLE, MODE_N_PASS
  - state encoding for IDLE/PLAY/DONE
- Sub-module waveform_channel_counter, generated CHANNELS times:
  - holds latched start/end, address, pass counter, finished flag.
  - inputs: load, advance, target.
  - outputs: address, last, finished.
- Top holds the FSM, the READ_LATENCY delay lines (word_valid, sync_out) and the passes_done counter.

## Test plan
- Mode 0, ch0 start 0x10/end 0x14, READ_LATENCY 2:
  - addresses 10,11,12,13,10… with no gap.
  - sync_out every 4 cycles, coincident with word_valid[0] for address 0x10.
- Mode 1, ch0 0..3, ch1 0..7, trigger:
  - ch0 read_enable low after 3 words; ch1 runs 7 words.
  - done 1 cycle after ch1's last word; passes_done = 1.
- Mode 2, loop_count 3, ch0 0x20..0x22:
  - exactly 6 words (20,21,20,21,20,21); passes_done = 3.
  - loop_count 0 gives exactly 2 words.
- Empty channel: ch2 end = start = 5 → read_enable[2] never high; sequence still reaches done.
- resync and trigger asserted together mid-pass at ch0 address 0x12 → address returns to start next cycle; passes_done = 0; sync_out pulses READ_LATENCY later.
- Reset asserted mid-PLAY:
  - next cycle all outputs are 0, including word_valid still in flight.
  - mode 0 with enable high restarts one cycle after reset deasserts.

Source files
------------

// File: rtl/waveform_playback_pkg.sv
// Shared mode constants and FSM state encoding for the waveform playback sequencer.
package waveform_playback_pkg;

  localparam logic [1:0] MODE_CONTINUOUS = 2'd0;
  localparam logic [1:0] MODE_SINGLE     = 2'd1;
  localparam logic [1:0] MODE_N_PASS     = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } play_state_t;

endpackage

// File: rtl/waveform_channel_counter.sv
// One playback channel: latched region, word address, pass counter and finished flag.
module waveform_channel_counter
  import waveform_playback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned PASS_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  halt,
  input  logic [PASS_WIDTH-1:0] target,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH-1:0] end_address,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  last,
  output logic                  finished,
  output logic                  live,
  output logic                  restart_c,
  output logic                  final_pass_c
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [PASS_WIDTH-1:0] PASS_ONE = PASS_WIDTH'(1);
  localparam logic [PASS_WIDTH-1:0] PASS_MAX = '1;

  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic [PASS_WIDTH-1:0] passes_q;

  logic [ADDR_WIDTH-1:0] start_d;
  logic [ADDR_WIDTH-1:0] end_d;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [PASS_WIDTH-1:0] passes_d;
  logic [PASS_WIDTH-1:0] passes_inc;
  logic                  live_d;
  logic                  finished_d;
  logic                  last_d;
  logic                  reload;

  // Next-state: load/wrap relatch the region, otherwise step or finish at the last word
  always_comb begin
    start_d      = start_q;
    end_d        = end_q;
    address_d    = address;
    passes_d     = passes_q;
    live_d       = live;
    finished_d   = finished;
    restart_c    = 1'b0;
    passes_inc   = (passes_q == PASS_MAX) ? passes_q : passes_q + PASS_ONE;
    // target of zero means unbounded (continuous mode)
    final_pass_c = (target != '0) && (passes_inc >= target);
    reload       = load || (advance && live && last && !final_pass_c);

    if (reload) begin
      start_d    = start_address;
      end_d      = end_address;
      address_d  = start_address;
      passes_d   = load ? '0 : passes_inc;
      live_d     = end_address > start_address;
      finished_d = !live_d;
      restart_c  = live_d;
    end else if (halt) begin
      live_d = 1'b0;
    end else if (advance && live) begin
      if (last) begin
        passes_d   = passes_inc;
        live_d     = 1'b0;
        finished_d = 1'b1;
      end else begin
        address_d = address + ADDR_ONE;
      end
    end

    // last is registered so the top sees it alongside the address it qualifies
    last_d = live_d && (address_d == end_d - ADDR_ONE);
  end

  // Channel state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q  <= '0;
      end_q    <= '0;
      address  <= '0;
      passes_q <= '0;
      live     <= 1'b0;
      finished <= 1'b0;
      last     <= 1'b0;
    end else begin
      start_q  <= start_d;
      end_q    <= end_d;
      address  <= address_d;
      passes_q <= passes_d;
      live     <= live_d;
      finished <= finished_d;
      last     <= last_d;
    end
  end

endmodule

// File: rtl/waveform_playback_sequencer.sv
// Multi-channel waveform memory address sequencer with continuous, single and N-pass playback.
module waveform_playback_sequencer
  import waveform_playback_pkg::*;
#(
  parameter int unsigned CHANNELS     = 6,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned PASS_WIDTH   = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  input  logic [PASS_WIDTH-1:0]          loop_count,
  input  logic                           trigger,
  input  logic                           resync,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] start_address,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] end_address,
  output logic [CHANNELS*ADDR_WIDTH-1:0] read_address,
  output logic [CHANNELS-1:0]            read_enable,
  output logic [CHANNELS-1:0]            word_valid,
  output logic                           sync_out,
  output logic                           busy,
  output logic                           done,
  output logic [PASS_WIDTH-1:0]          passes_done
);

  localparam logic [PASS_WIDTH-1:0] PASS_ONE = PASS_WIDTH'(1);
  localparam logic [PASS_WIDTH-1:0] PASS_MAX = '1;

  play_state_t           state;
  logic [PASS_WIDTH-1:0] target;
  logic                  sync_pulse;

  logic                  enter_c;
  logic                  resync_c;
  logic                  load_c;
  logic                  advance_c;
  logic                  halt_c;
  logic                  all_finish_c;
  logic [PASS_WIDTH-1:0] entry_target_c;
  logic [CHANNELS-1:0]   pass_end_c;

  logic [CHANNELS-1:0]   last;
  logic [CHANNELS-1:0]   finished;
  logic [CHANNELS-1:0]   restart_c;
  logic [CHANNELS-1:0]   final_pass_c;

  // Control decode: start, restart, stepping and completion lookahead
  always_comb begin
    enter_c        = (state == ST_IDLE) && enable && ((mode == MODE_CONTINUOUS) || trigger);
    resync_c       = (state == ST_PLAY) && enable && resync;
    load_c         = enter_c || resync_c;
    advance_c      = (state == ST_PLAY) && enable && !resync;
    halt_c         = !enable;
    pass_end_c     = {CHANNELS{advance_c}} & read_enable & last;
    // every channel is already finished or finishes on this edge
    all_finish_c   = &(finished | (pass_end_c & final_pass_c));
    entry_target_c = PASS_ONE;
    case (mode)
      MODE_CONTINUOUS: entry_target_c = '0;
      MODE_N_PASS:     entry_target_c = (loop_count == '0) ? PASS_ONE : loop_count;
      default:         entry_target_c = PASS_ONE;
    endcase
  end

  // Per-channel address generators
  for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
    waveform_channel_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PASS_WIDTH (PASS_WIDTH)
    ) u_channel (
      .clock         (clock),
      .reset         (reset),
      .load          (load_c),
      .advance       (advance_c),
      .halt          (halt_c),
      .target        (target),
      .start_address (start_address[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .end_address   (end_address[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .address       (read_address[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .last          (last[c]),
      .finished      (finished[c]),
      .live          (read_enable[c]),
      .restart_c     (restart_c[c]),
      .final_pass_c  (final_pass_c[c])
    );
  end

  // Sequencer FSM with registered busy/done and the pass target latched on entry
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      target <= '0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (enter_c) begin
              state  <= ST_PLAY;
              busy   <= 1'b1;
              target <= entry_target_c;
            end
          end
          ST_PLAY: begin
            if (!resync && (target != '0) && all_finish_c) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Channel-0 completed-pass counter, cleared on every (re)start, saturating
  always_ff @(posedge clock) begin
    if (reset) begin
      passes_done <= '0;
    end else if (load_c) begin
      passes_done <= '0;
    end else if (pass_end_c[0] && (passes_done != PASS_MAX)) begin
      passes_done <= passes_done + PASS_ONE;
    end
  end

  // Undelayed sync: high in the cycle channel 0 presents its start address
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_pulse <= 1'b0;
    end else begin
      sync_pulse <= restart_c[0];
    end
  end

  // Align word_valid and sync_out with memory read data
  if (READ_LATENCY == 0) begin : g_no_delay
    assign word_valid = read_enable;
    assign sync_out   = sync_pulse;
  end else begin : g_delay
    logic [READ_LATENCY-1:0][CHANNELS-1:0] valid_pipe;
    logic [READ_LATENCY-1:0]               sync_pipe;

    for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
      if (i == 0) begin : g_first
        // First delay stage fed from the live address qualifiers
        always_ff @(posedge clock) begin
          if (reset) begin
            valid_pipe[i] <= '0;
            sync_pipe[i]  <= 1'b0;
          end else begin
            valid_pipe[i] <= read_enable;
            sync_pipe[i]  <= sync_pulse;
          end
        end
      end else begin : g_next
        // Subsequent delay stages
        always_ff @(posedge clock) begin
          if (reset) begin
            valid_pipe[i] <= '0;
            sync_pipe[i]  <= 1'b0;
          end else begin
            valid_pipe[i] <= valid_pipe[i-1];
            sync_pipe[i]  <= sync_pipe[i-1];
          end
        end
      end
    end

    assign word_valid = valid_pipe[READ_LATENCY-1];
    assign sync_out   = sync_pipe[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_waveform_playback_sequencer.sv
// Self-checking bench: directed scenarios plus randomized runs against a cycle-count reference model.
`timescale 1ns/1ps
module tb_waveform_playback_sequencer;

  localparam int CH   = 4;
  localparam int AW   = 8;
  localparam int RL   = 2;
  localparam int PW   = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [1:0]      mode;
  logic [PW-1:0]   loop_count;
  logic            trigger;
  logic            resync;
  logic [CH*AW-1:0] start_address;
  logic [CH*AW-1:0] end_address;
  logic [CH*AW-1:0] read_address;
  logic [CH-1:0]   read_enable;
  logic [CH-1:0]   word_valid;
  logic            sync_out;
  logic            busy;
  logic            done;
  logic [PW-1:0]   passes_done;

  int tests_run    = 0;
  int tests_failed = 0;

  waveform_playback_sequencer #(
    .CHANNELS     (CH),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL),
    .PASS_WIDTH   (PW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .loop_count    (loop_count),
    .trigger       (trigger),
    .resync        (resync),
    .start_address (start_address),
    .end_address   (end_address),
    .read_address  (read_address),
    .read_enable   (read_enable),
    .word_valid    (word_valid),
    .sync_out      (sync_out),
    .busy          (busy),
    .done          (done),
    .passes_done   (passes_done)
  );

  always #5 clock = ~clock;

  // Reference model: k counts cycles since the current run (re)started.
  // Channel c shows start + k mod len while k < len*target.
  typedef enum int {P_IDLE, P_PLAY, P_DONE} phase_t;
  phase_t      ph;
  int          k;
  int          tgt;
  int          st   [CH];
  int          len  [CH];
  int          m_addr [CH];
  int          m_passes;
  logic        m_busy;
  logic        m_done;
  logic [CH-1:0] re_h [0:RL];
  logic        sync_h [0:RL];
  int          words0;
  int          done_count;
  logic        re2_seen;

  function automatic void latch_regions();
    for (int c = 0; c < CH; c++) begin
      int s;
      int e;
      s = int'(start_address[c*AW +: AW]);
      e = int'(end_address[c*AW +: AW]);
      st[c]  = s;
      len[c] = (e > s) ? e - s : 0;
    end
  endfunction

  function automatic int span();
    int m;
    m = 1;
    for (int c = 0; c < CH; c++)
      if (len[c] * tgt > m) m = len[c] * tgt;
    return m;
  endfunction

  function automatic int model_passes();
    int p;
    if (len[0] == 0) return 0;
    p = k / len[0];
    if (tgt != 0 && p > tgt) p = tgt;
    if (p > PMAX) p = PMAX;
    return p;
  endfunction

  task automatic model_reset();
    ph = P_IDLE;
    k = 0;
    tgt = 0;
    m_passes = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_addr[c] = 0;
      st[c] = 0;
      len[c] = 0;
    end
    for (int i = 0; i <= RL; i++) begin
      re_h[i] = '0;
      sync_h[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = RL; i > 0; i--) begin
      re_h[i]   = re_h[i-1];
      sync_h[i] = sync_h[i-1];
    end
    if (reset) begin
      model_reset();
      return;
    end
    if (!enable) begin
      ph = P_IDLE;
    end else begin
      case (ph)
        P_IDLE: if (mode == 2'd0 || trigger) begin
          ph = P_PLAY;
          k = 0;
          if (mode == 2'd0) tgt = 0;
          else if (mode == 2'd2) tgt = (loop_count == 0) ? 1 : int'(loop_count);
          else tgt = 1;
          latch_regions();
        end
        P_PLAY: if (resync) begin
          k = 0;
          latch_regions();
        end else if (tgt != 0 && k + 1 >= span()) begin
          ph = P_DONE;
          k++;
        end else begin
          k++;
        end
        default: ph = P_IDLE;
      endcase
    end
    re_h[0]   = '0;
    sync_h[0] = 1'b0;
    m_busy    = (ph == P_PLAY);
    m_done    = (ph == P_DONE);
    if (ph == P_PLAY) begin
      for (int c = 0; c < CH; c++) begin
        if (len[c] == 0) m_addr[c] = st[c];
        else if (tgt == 0 || k < len[c] * tgt) begin
          re_h[0][c] = 1'b1;
          m_addr[c] = st[c] + k % len[c];
        end else m_addr[c] = st[c] + len[c] - 1;
      end
      if (len[0] != 0) sync_h[0] = re_h[0][0] && (k % len[0] == 0);
    end
    if (ph != P_IDLE) m_passes = model_passes();
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
      end
  endtask

  task automatic check_all();
    logic [CH*AW-1:0] ea;
    for (int c = 0; c < CH; c++) ea[c*AW +: AW] = AW'(m_addr[c]);
    check("read_address", 64'(read_address), 64'(ea));
    check("read_enable",  64'(read_enable),  64'(re_h[0]));
    check("word_valid",   64'(word_valid),   64'(re_h[RL]));
    check("sync_out",     64'(sync_out),     64'(sync_h[RL]));
    check("busy",         64'(busy),         64'(m_busy));
    check("done",         64'(done),         64'(m_done));
    check("passes_done",  64'(passes_done),  64'(m_passes));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
    words0     += int'(read_enable[0]);
    done_count += int'(done);
    re2_seen   |= read_enable[2];
    trigger = 1'b0;
    resync  = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_to_idle(input int bound);
    for (int i = 0; i < bound && ph != P_IDLE; i++) cycle();
  endtask

  task automatic set_region(input int c, input int s, input int e);
    start_address[c*AW +: AW] = AW'(s);
    end_address[c*AW +: AW]   = AW'(e);
  endtask

  task automatic clear_counts();
    words0 = 0;
    done_count = 0;
    re2_seen = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    mode = 2'd0;
    loop_count = '0;
    trigger = 1'b0;
    resync = 1'b0;
    start_address = '0;
    end_address = '0;
    model_reset();
    clear_counts();

    // Reset state
    run(3);
    reset = 1'b0;
    run(2);

    // Continuous loop 0x10..0x13 with zero-cycle wrap
    set_region(0, 'h10, 'h14);
    set_region(1, 'h40, 'h43);
    set_region(2, 5, 5);
    set_region(3, 'h80, 'h81);
    mode = 2'd0;
    enable = 1'b1;
    run(14);

    // resync together with trigger while channel 0 shows 0x12
    for (int i = 0; i < 8 && m_addr[0] != 'h12; i++) cycle();
    resync = 1'b1;
    trigger = 1'b1;
    cycle();
    check("resync_address", 64'(read_address[AW-1:0]), 64'h10);
    check("resync_passes",  64'(passes_done), 64'h0);
    run(RL);
    check("resync_sync", 64'(sync_out), 64'h1);
    run(6);

    // Reset mid-PLAY flushes in-flight valids, then restarts in continuous mode
    reset = 1'b1;
    cycle();
    check("reset_word_valid", 64'(word_valid), 64'h0);
    reset = 1'b0;
    run(6);
    enable = 1'b0;
    run(4);

    // Single pass: ch0 3 words, ch1 7 words, ch2 empty
    set_region(0, 0, 3);
    set_region(1, 0, 7);
    set_region(2, 5, 5);
    set_region(3, 9, 2);
    mode = 2'd1;
    enable = 1'b1;
    run(2);
    clear_counts();
    trigger = 1'b1;
    cycle();
    run_to_idle(40);
    run(RL + 1);
    check("single_words0", 64'(words0), 64'd3);
    check("single_passes", 64'(passes_done), 64'd1);
    check("single_done_count", 64'(done_count), 64'd1);
    check("empty_ch2_never_live", 64'(re2_seen), 64'd0);

    // N passes with loop_count 3 and loop_count 0
    set_region(0, 'h20, 'h22);
    set_region(1, 3, 3);
    set_region(2, 7, 7);
    set_region(3, 1, 0);
    mode = 2'd2;
    loop_count = 4'd3;
    clear_counts();
    trigger = 1'b1;
    cycle();
    run_to_idle(40);
    run(RL + 1);
    check("npass3_words0", 64'(words0), 64'd6);
    check("npass3_passes", 64'(passes_done), 64'd3);
    loop_count = 4'd0;
    clear_counts();
    trigger = 1'b1;
    cycle();
    run_to_idle(40);
    run(RL + 1);
    check("npass0_words0", 64'(words0), 64'd2);
    check("npass0_passes", 64'(passes_done), 64'd1);

    // passes_done saturation with a one-word region
    set_region(0, 7, 8);
    mode = 2'd0;
    run(20);
    check("passes_saturate", 64'(passes_done), 64'(PMAX));
    enable = 1'b0;
    run(RL + 1);

    // Randomized triggered runs with occasional resync/trigger noise
    enable = 1'b1;
    repeat (25) begin
      for (int c = 0; c < CH; c++) begin
        int s;
        int l;
        s = int'($urandom_range(0, 200));
        l = int'($urandom_range(0, 6));
        set_region(c, s, (l == 0) ? int'($urandom_range(0, s)) : s + l);
      end
      mode = 2'($urandom_range(1, 3));
      loop_count = PW'($urandom_range(0, 3));
      run(int'($urandom_range(0, 2)));
      trigger = 1'b1;
      cycle();
      for (int i = 0; i < 200 && ph != P_IDLE; i++) begin
        if ($urandom_range(0, 39) == 0) resync = 1'b1;
        if ($urandom_range(0, 9) == 0) trigger = 1'b1;
        cycle();
      end
      run(RL + 1);
    end

    // Randomized continuous runs with resync and enable drops
    repeat (4) begin
      for (int c = 0; c < CH; c++) begin
        int s;
        s = int'($urandom_range(0, 200));
        set_region(c, s, s + int'($urandom_range(0, 5)));
      end
      mode = 2'd0;
      for (int i = 0; i < 40; i++) begin
        enable = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 11) == 0) resync = 1'b1;
        cycle();
      end
      enable = 1'b0;
      run(RL + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
